// File: rtl/cpu_clk_ctrl.sv
// CPU clock-enable sequencer: free-run at a divided rate or single-step from a
// debounced button, with halt/resume and a 32-bit issued-cycle counter.
module cpu_clk_ctrl #(
  parameter int CNT_W      = 24,
  parameter int RATE1_LOG  = 17,
  parameter int RATE2_LOG  = 20,
  parameter int DEB_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [1:0]  rate_sel,
  input  logic        mode_run,
  input  logic        step_btn,
  input  logic        cpu_halt,
  input  logic        resume,
  output logic        cpu_ce,
  output logic [31:0] cycle_count,
  output logic [1:0]  state,
  output logic        halted
);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_STEP = 2'b10;
  localparam logic [1:0] S_HALT = 2'b11;

  localparam int DEB_W = $clog2(DEB_CYCLES);
  localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB_CYCLES - 1);

  logic [CNT_W-1:0] div;
  logic             tick;
  logic             btn_meta;
  logic             btn_sync;
  logic             btn_stable;
  logic             btn_stable_d;
  logic [DEB_W-1:0] deb_cnt;
  logic             step_press;
  logic [1:0]       state_next;
  logic             ce_next;

  // Divider runs from reset forever; mode and state changes never touch it.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) div <= '0;
    else     div <= div + 1'b1;
  end

  always_comb begin
    case (rate_sel)
      2'd0:    tick = 1'b1;
      2'd1:    tick = &div[RATE1_LOG-1:0];
      2'd2:    tick = &div[RATE2_LOG-1:0];
      default: tick = &div;
    endcase
  end

  // The debounce counter only advances while the synchronised level disagrees
  // with the accepted level; any bounce back to the accepted level restarts it.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      btn_meta     <= 1'b0;
      btn_sync     <= 1'b0;
      btn_stable   <= 1'b0;
      btn_stable_d <= 1'b0;
      deb_cnt      <= '0;
    end else begin
      btn_meta     <= step_btn;
      btn_sync     <= btn_meta;
      btn_stable_d <= btn_stable;
      if (btn_sync == btn_stable) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_MAX) begin
        btn_stable <= btn_sync;
        deb_cnt    <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  assign step_press = btn_stable & ~btn_stable_d;

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (cpu_halt)      state_next = S_HALT;
        else if (mode_run) state_next = S_RUN;
        else               state_next = S_STEP;
      end
      S_RUN: begin
        if (cpu_halt)       state_next = S_HALT;
        else if (!mode_run) state_next = S_STEP;
      end
      S_STEP: begin
        if (cpu_halt)      state_next = S_HALT;
        else if (mode_run) state_next = S_RUN;
      end
      default: begin
        if (resume && !cpu_halt) state_next = mode_run ? S_RUN : S_STEP;
      end
    endcase
  end

  // Enable follows the current state, so a tick or press on a mode-change edge obeys the old mode.
  assign ce_next = !cpu_halt &&
                   (((state == S_RUN) && tick) || ((state == S_STEP) && step_press));

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state       <= S_IDLE;
      halted      <= 1'b0;
      cpu_ce      <= 1'b0;
      cycle_count <= '0;
    end else begin
      state  <= state_next;
      halted <= (state_next == S_HALT);
      cpu_ce <= ce_next;
      if (ce_next) cycle_count <= cycle_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Directed bench for cpu_clk_ctrl with small divider/debounce parameters.
module tb_cpu_clk_ctrl;

  logic        clk = 1'b0;
  logic        clr;
  logic [1:0]  rate_sel;
  logic        mode_run;
  logic        step_btn;
  logic        cpu_halt;
  logic        resume;
  logic        cpu_ce;
  logic [31:0] cycle_count;
  logic [1:0]  state;
  logic        halted;

  int errors = 0;
  int checks = 0;

  cpu_clk_ctrl #(
    .CNT_W(8), .RATE1_LOG(2), .RATE2_LOG(4), .DEB_CYCLES(4)
  ) dut (
    .clk(clk), .clr(clr), .rate_sel(rate_sel), .mode_run(mode_run),
    .step_btn(step_btn), .cpu_halt(cpu_halt), .resume(resume),
    .cpu_ce(cpu_ce), .cycle_count(cycle_count), .state(state), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic run, input logic [1:0] rate, input logic halt,
                               input logic res, input logic btn);
    mode_run = run;
    rate_sel = rate;
    cpu_halt = halt;
    resume   = res;
    step_btn = btn;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Sample index i is the negedge after the i-th rising edge of the window.
  task automatic countPulses(input int n, output int pulses, output int first);
    pulses = 0;
    first  = -1;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (cpu_ce) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int p, f, bounce;
    logic [31:0] c0;
    int windows [3] = '{64, 256, 512};
    int expect_p [3] = '{16, 16, 2};

    clr = 1'b1;
    applyStimulus(1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    cycles(2);
    checkOutput("rst_state", state, 2'b00);
    checkOutput("rst_ce", cpu_ce, 1'b0);
    checkOutput("rst_count", cycle_count, 32'd0);
    checkOutput("rst_halted", halted, 1'b0);

    clr = 1'b0;
    #1 checkOutput("idle_hold", state, 2'b00);
    cycles(1);
    checkOutput("idle_to_run", state, 2'b01);
    checkOutput("idle_no_ce", cpu_ce, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycles(1);
      checkOutput("rate0_ce", cpu_ce, 1'b1);
    end
    checkOutput("rate0_count10", cycle_count, 32'd10);

    for (int r = 1; r <= 3; r++) begin
      rate_sel = 2'(r);
      c0 = cycle_count;
      countPulses(windows[r-1], p, f);
      checkOutput($sformatf("rate%0d_pulses", r), p, expect_p[r-1]);
      checkOutput($sformatf("rate%0d_count", r), cycle_count - c0, expect_p[r-1]);
    end

    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    cycles(2);
    checkOutput("step_state", state, 2'b10);
    c0 = cycle_count;
    countPulses(5, p, f);
    checkOutput("step_idle_ce", p, 0);
    bounce = 0;
    for (int i = 0; i < 12; i++) begin
      step_btn = ((i / 2) % 2 == 0);
      @(negedge clk);
      if (cpu_ce) bounce++;
    end
    checkOutput("bounce_no_ce", bounce, 0);
    step_btn = 1'b1;
    countPulses(20, p, f);
    checkOutput("press_one_ce", p, 1);
    checkOutput("press_latency", f, 7);
    step_btn = 1'b0;
    countPulses(15, p, f);
    checkOutput("release_no_ce", p, 0);
    checkOutput("step_count", cycle_count - c0, 32'd1);

    mode_run = 1'b1;
    cycles(2);
    checkOutput("back_to_run", state, 2'b01);
    cpu_halt = 1'b1;
    cycles(1);
    cpu_halt = 1'b0;
    checkOutput("halt_state", state, 2'b11);
    checkOutput("halt_flag", halted, 1'b1);
    checkOutput("halt_entry_ce", cpu_ce, 1'b0);
    countPulses(4, p, f);
    checkOutput("halt_no_ce", p, 0);
    resume = 1'b1; cpu_halt = 1'b1;
    cycles(1);
    resume = 1'b0; cpu_halt = 1'b0;
    checkOutput("resume_ignored", state, 2'b11);
    step_btn = 1'b1;
    countPulses(12, p, f);
    step_btn = 1'b0;
    countPulses(10, f, bounce);
    checkOutput("halt_press_no_ce", p + f, 0);
    resume = 1'b1;
    cycles(1);
    resume = 1'b0;
    checkOutput("resume_state", state, 2'b01);
    checkOutput("resume_halted", halted, 1'b0);
    checkOutput("resume_first_ce", cpu_ce, 1'b0);
    cycles(1);
    checkOutput("resume_ce", cpu_ce, 1'b1);

    cpu_halt = 1'b1;
    cycles(1);
    cpu_halt = 1'b0;
    checkOutput("halt2_state", state, 2'b11);
    force dut.cycle_count = 32'hFFFF_FFFE;
    cycles(1);
    release dut.cycle_count;
    checkOutput("preload", cycle_count, 32'hFFFF_FFFE);
    resume = 1'b1;
    cycles(1);
    resume = 1'b0;
    checkOutput("wrap_first_ce", cpu_ce, 1'b0);
    cycles(3);
    checkOutput("wrap_ce", cpu_ce, 1'b1);
    checkOutput("wrap_count", cycle_count, 32'h0000_0001);

    step_btn = 1'b1;
    cycles(3);
    checkOutput("pre_clr_ce", cpu_ce, 1'b1);
    #2 clr = 1'b1;
    #1;
    checkOutput("clr_ce", cpu_ce, 1'b0);
    checkOutput("clr_count", cycle_count, 32'd0);
    checkOutput("clr_state", state, 2'b00);
    checkOutput("clr_halted", halted, 1'b0);
    mode_run = 1'b0;
    @(negedge clk);
    clr = 1'b0;
    countPulses(20, p, f);
    checkOutput("restab_one_ce", p, 1);
    checkOutput("restab_latency", f, 7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
